// File: rtl/config_pkg.sv
// Minimal core-configuration package: only the fields the landing-pad
// tracker needs. A full core build provides the complete version.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64};

endpackage

// File: rtl/lpad_elp_tracker.sv
// Zicfilp expected-landing-pad tracker on the commit side.
// It arms ELP on a committed non-exempt indirect jump and latches the x7 label.
// The next commit must be a matching LPAD, otherwise a software-check fault is
// raised and commit is stalled until trap entry. ELP is saved on trap entry and
// restored on xRET.
module lpad_elp_tracker #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
  parameter int unsigned           LabelWidth = 20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         xlpad_en_i,
  input  logic                         debug_mode_i,
  input  logic                         commit_valid_i,
  output logic                         commit_ready_o,
  input  logic                         commit_is_ijump_i,
  input  logic [4:0]                   commit_rs1_i,
  input  logic [LabelWidth-1:0]        commit_x7_label_i,
  input  logic                         commit_is_lpad_i,
  input  logic [LabelWidth-1:0]        commit_lpad_label_i,
  input  logic                         trap_taken_i,
  input  logic                         xret_i,
  input  logic                         pelp_restore_i,
  output logic                         elp_o,
  output logic [LabelWidth-1:0]        expected_label_o,
  output logic                         pelp_o,
  output logic                         lp_fault_valid_o,
  output logic [CVA6Cfg.XLEN-1:0]      lp_fault_cause_o,
  output logic [CVA6Cfg.XLEN-1:0]      lp_fault_tval_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPECT,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [LabelWidth-1:0] label_q, label_d;
  logic                  pelp_q, pelp_d;

  logic c_ev;
  logic rs1_exempt;
  logic lpad_match;

  // Outputs come straight from registers, so nothing on the commit inputs
  // reaches elp_o in the same cycle.
  assign commit_ready_o   = (state_q != S_FAULT);
  assign elp_o            = (state_q != S_IDLE);
  assign lp_fault_valid_o = (state_q == S_FAULT);
  assign expected_label_o = label_q;
  assign pelp_o           = pelp_q;
  assign lp_fault_cause_o = XLEN'(18);
  assign lp_fault_tval_o  = XLEN'(2);

  assign c_ev       = commit_valid_i && commit_ready_o;
  assign rs1_exempt = (commit_rs1_i == 5'd1) || (commit_rs1_i == 5'd5) ||
                      (commit_rs1_i == 5'd7);
  assign lpad_match = commit_is_lpad_i &&
                      ((commit_lpad_label_i == '0) || (commit_lpad_label_i == label_q));

  // Next-state: trap entry beats xRET, which beats any commit in the same cycle.
  always_comb begin
    state_d = state_q;
    label_d = label_q;
    pelp_d  = pelp_q;
    if (trap_taken_i) begin
      pelp_d  = elp_o;
      state_d = S_IDLE;
    end else if (xret_i) begin
      state_d = (pelp_restore_i && xlpad_en_i) ? S_EXPECT : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (c_ev && commit_is_ijump_i && !rs1_exempt && xlpad_en_i && !debug_mode_i) begin
            state_d = S_EXPECT;
            label_d = commit_x7_label_i;
          end
        end
        S_EXPECT: begin
          // Disabling landing pads abandons the expectation even if a
          // commit arrives in the same cycle.
          if (!xlpad_en_i) begin
            state_d = S_IDLE;
          end else if (c_ev) begin
            state_d = lpad_match ? S_IDLE : S_FAULT;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, label and saved-ELP registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      label_q <= '0;
      pelp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      label_q <= label_d;
      pelp_q  <= pelp_d;
    end
  end

endmodule

// File: tb/tb_lpad_elp_tracker.sv
// Self-checking bench for lpad_elp_tracker: directed scenarios followed by
// randomized traffic checked against a behavioural ELP model.
module tb_lpad_elp_tracker;

  localparam int XLEN = 64;
  localparam int LW   = 20;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          xlpad_en_i;
  logic          debug_mode_i;
  logic          commit_valid_i;
  logic          commit_ready_o;
  logic          commit_is_ijump_i;
  logic [4:0]    commit_rs1_i;
  logic [LW-1:0] commit_x7_label_i;
  logic          commit_is_lpad_i;
  logic [LW-1:0] commit_lpad_label_i;
  logic          trap_taken_i;
  logic          xret_i;
  logic          pelp_restore_i;
  logic          elp_o;
  logic [LW-1:0] expected_label_o;
  logic          pelp_o;
  logic          lp_fault_valid_o;
  logic [XLEN-1:0] lp_fault_cause_o;
  logic [XLEN-1:0] lp_fault_tval_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: whether a landing pad is owed, whether a fault is
  // pending, the remembered label and the saved previous ELP.
  bit          m_exp, m_fault, m_pelp;
  bit [LW-1:0] m_label;

  lpad_elp_tracker #(
    .CVA6Cfg   (config_pkg::cva6_cfg_empty),
    .LabelWidth(LW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .xlpad_en_i         (xlpad_en_i),
    .debug_mode_i       (debug_mode_i),
    .commit_valid_i     (commit_valid_i),
    .commit_ready_o     (commit_ready_o),
    .commit_is_ijump_i  (commit_is_ijump_i),
    .commit_rs1_i       (commit_rs1_i),
    .commit_x7_label_i  (commit_x7_label_i),
    .commit_is_lpad_i   (commit_is_lpad_i),
    .commit_lpad_label_i(commit_lpad_label_i),
    .trap_taken_i       (trap_taken_i),
    .xret_i             (xret_i),
    .pelp_restore_i     (pelp_restore_i),
    .elp_o              (elp_o),
    .expected_label_o   (expected_label_o),
    .pelp_o             (pelp_o),
    .lp_fault_valid_o   (lp_fault_valid_o),
    .lp_fault_cause_o   (lp_fault_cause_o),
    .lp_fault_tval_o    (lp_fault_tval_o)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the model from the inputs held across the
  // edge; returns 1 time unit after the edge so outputs can be sampled.
  task automatic step();
    bit          n_exp, n_fault, n_pelp;
    bit [LW-1:0] n_label;
    bit          cev, exempt;
    n_exp = m_exp; n_fault = m_fault; n_pelp = m_pelp; n_label = m_label;
    cev    = commit_valid_i && !m_fault;
    exempt = (commit_rs1_i == 1) || (commit_rs1_i == 5) || (commit_rs1_i == 7);
    if (rst_i) begin
      n_exp = 0; n_fault = 0; n_pelp = 0; n_label = '0;
    end else if (trap_taken_i) begin
      n_pelp = m_exp || m_fault; n_exp = 0; n_fault = 0;
    end else if (xret_i) begin
      n_exp = pelp_restore_i && xlpad_en_i; n_fault = 0;
    end else if (m_fault) begin
      n_fault = 1;
    end else if (m_exp) begin
      if (!xlpad_en_i) n_exp = 0;
      else if (cev) begin
        n_exp = 0;
        n_fault = !(commit_is_lpad_i && (commit_lpad_label_i == 0 || commit_lpad_label_i == m_label));
      end
    end else if (cev && commit_is_ijump_i && !exempt && xlpad_en_i && !debug_mode_i) begin
      n_exp = 1; n_label = commit_x7_label_i;
    end
    @(posedge clk);
    #1;
    m_exp = n_exp; m_fault = n_fault; m_pelp = n_pelp; m_label = n_label;
  endtask

  task automatic quiet();
    rst_i = 0; xlpad_en_i = 1; debug_mode_i = 0; commit_valid_i = 0;
    commit_is_ijump_i = 0; commit_rs1_i = '0; commit_x7_label_i = '0;
    commit_is_lpad_i = 0; commit_lpad_label_i = '0;
    trap_taken_i = 0; xret_i = 0; pelp_restore_i = 0;
  endtask

  task automatic commit_ijump(input logic [4:0] rs1, input logic [LW-1:0] lab);
    commit_valid_i = 1; commit_is_ijump_i = 1; commit_rs1_i = rs1; commit_x7_label_i = lab;
    step();
    commit_valid_i = 0; commit_is_ijump_i = 0;
  endtask

  task automatic commit_lpad(input logic [LW-1:0] lab);
    commit_valid_i = 1; commit_is_lpad_i = 1; commit_lpad_label_i = lab;
    step();
    commit_valid_i = 0; commit_is_lpad_i = 0;
  endtask

  task automatic commit_other();
    commit_valid_i = 1;
    step();
    commit_valid_i = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    step();
    n_cmp++; if (elp_o !== 1'b0) begin n_fail++; $display("FAIL reset_elp: got %b want 0", elp_o); end
    n_cmp++; if (lp_fault_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", lp_fault_valid_o); end
    n_cmp++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", commit_ready_o); end
    n_cmp++; if (pelp_o !== 1'b0) begin n_fail++; $display("FAIL reset_pelp: got %b want 0", pelp_o); end
    n_cmp++; if (expected_label_o !== '0) begin n_fail++; $display("FAIL reset_label: got %h want 0", expected_label_o); end
  endtask

  task automatic test_match();
    commit_ijump(5'd10, 20'h12345);
    n_cmp++; if (elp_o !== 1'b1) begin n_fail++; $display("FAIL match_arm_elp: got %b want 1", elp_o); end
    n_cmp++; if (expected_label_o !== 20'h12345) begin n_fail++; $display("FAIL match_label: got %h want 12345", expected_label_o); end
    commit_lpad(20'h12345);
    n_cmp++; if (elp_o !== 1'b0) begin n_fail++; $display("FAIL match_clear_elp: got %b want 0", elp_o); end
    n_cmp++; if (lp_fault_valid_o !== 1'b0) begin n_fail++; $display("FAIL match_no_fault: got %b want 0", lp_fault_valid_o); end
  endtask

  task automatic test_mismatch_trap();
    commit_ijump(5'd10, 20'h00ABC);
    commit_lpad(20'h00ABD);
    n_cmp++; if (lp_fault_valid_o !== 1'b1) begin n_fail++; $display("FAIL mm_fault: got %b want 1", lp_fault_valid_o); end
    n_cmp++; if (lp_fault_cause_o !== 64'd18) begin n_fail++; $display("FAIL mm_cause: got %0d want 18", lp_fault_cause_o); end
    n_cmp++; if (lp_fault_tval_o !== 64'd2) begin n_fail++; $display("FAIL mm_tval: got %0d want 2", lp_fault_tval_o); end
    n_cmp++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL mm_ready: got %b want 0", commit_ready_o); end
    commit_valid_i = 1; commit_is_lpad_i = 1; commit_lpad_label_i = 20'h00ABC;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (lp_fault_valid_o !== 1'b1 || commit_ready_o !== 1'b0 || elp_o !== 1'b1)
        begin n_fail++; $display("FAIL mm_hold%0d: got fault=%b ready=%b elp=%b want 1 0 1", i, lp_fault_valid_o, commit_ready_o, elp_o); end
    end
    commit_valid_i = 0; commit_is_lpad_i = 0;
    trap_taken_i = 1;
    step();
    trap_taken_i = 0;
    n_cmp++; if (pelp_o !== 1'b1) begin n_fail++; $display("FAIL mm_trap_pelp: got %b want 1", pelp_o); end
    n_cmp++; if (commit_ready_o !== 1'b1 || lp_fault_valid_o !== 1'b0 || elp_o !== 1'b0)
      begin n_fail++; $display("FAIL mm_trap_idle: got ready=%b fault=%b elp=%b want 1 0 0", commit_ready_o, lp_fault_valid_o, elp_o); end
  endtask

  task automatic test_zero_label_and_exempt();
    logic [4:0] ex [3] = '{5'd1, 5'd5, 5'd7};
    commit_ijump(5'd10, 20'h00777);
    commit_lpad('0);
    n_cmp++; if (elp_o !== 1'b0 || lp_fault_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL zero_label: got elp=%b fault=%b want 0 0", elp_o, lp_fault_valid_o); end
    foreach (ex[i]) begin
      commit_ijump(ex[i], 20'h0BEEF);
      n_cmp++; if (elp_o !== 1'b0) begin n_fail++; $display("FAIL exempt_x%0d_elp: got %b want 0", ex[i], elp_o); end
      commit_other();
      n_cmp++; if (elp_o !== 1'b0 || lp_fault_valid_o !== 1'b0)
        begin n_fail++; $display("FAIL exempt_x%0d_add: got elp=%b fault=%b want 0 0", ex[i], elp_o, lp_fault_valid_o); end
    end
  endtask

  task automatic test_trap_xret();
    commit_ijump(5'd10, 20'h00055);
    trap_taken_i = 1; commit_valid_i = 1;
    step();
    trap_taken_i = 0; commit_valid_i = 0;
    n_cmp++; if (lp_fault_valid_o !== 1'b0 || elp_o !== 1'b0 || pelp_o !== 1'b1)
      begin n_fail++; $display("FAIL trap_commit: got fault=%b elp=%b pelp=%b want 0 0 1", lp_fault_valid_o, elp_o, pelp_o); end
    xret_i = 1; pelp_restore_i = 1;
    step();
    xret_i = 0; pelp_restore_i = 0;
    n_cmp++; if (elp_o !== 1'b1) begin n_fail++; $display("FAIL xret_restore: got %b want 1", elp_o); end
    n_cmp++; if (expected_label_o !== 20'h00055) begin n_fail++; $display("FAIL xret_label: got %h want 00055", expected_label_o); end
    commit_other();
    n_cmp++; if (lp_fault_valid_o !== 1'b1) begin n_fail++; $display("FAIL xret_then_add: got %b want 1", lp_fault_valid_o); end
    trap_taken_i = 1;
    step();
    trap_taken_i = 0;
  endtask

  task automatic test_fault_reset();
    commit_ijump(5'd12, 20'h00321);
    commit_other();
    n_cmp++; if (lp_fault_valid_o !== 1'b1) begin n_fail++; $display("FAIL fr_fault: got %b want 1", lp_fault_valid_o); end
    rst_i = 1; trap_taken_i = 1;
    step();
    rst_i = 0; trap_taken_i = 0;
    n_cmp++; if (elp_o !== 1'b0 || lp_fault_valid_o !== 1'b0 || commit_ready_o !== 1'b1 || pelp_o !== 1'b0 || expected_label_o !== '0)
      begin n_fail++; $display("FAIL fr_outputs: got elp=%b fault=%b ready=%b pelp=%b label=%h want 0 0 1 0 0", elp_o, lp_fault_valid_o, commit_ready_o, pelp_o, expected_label_o); end
  endtask

  task automatic test_disabled();
    debug_mode_i = 1;
    commit_ijump(5'd10, 20'h00001);
    debug_mode_i = 0;
    n_cmp++; if (elp_o !== 1'b0) begin n_fail++; $display("FAIL debug_elp: got %b want 0", elp_o); end
    xlpad_en_i = 0;
    commit_ijump(5'd10, 20'h00001);
    n_cmp++; if (elp_o !== 1'b0) begin n_fail++; $display("FAIL disabled_elp: got %b want 0", elp_o); end
    xlpad_en_i = 1;
    commit_ijump(5'd10, 20'h00002);
    xlpad_en_i = 0; commit_valid_i = 1;
    step();
    xlpad_en_i = 1; commit_valid_i = 0;
    n_cmp++; if (elp_o !== 1'b0 || lp_fault_valid_o !== 1'b0)
      begin n_fail++; $display("FAIL en_drop: got elp=%b fault=%b want 0 0", elp_o, lp_fault_valid_o); end
  endtask

  task automatic test_random();
    logic [LW-1:0] labs [4] = '{20'h00000, 20'h00011, 20'h00022, 20'hFFFFF};
    for (int i = 0; i < 3000; i++) begin
      rst_i             = ($urandom_range(0, 199) == 0);
      trap_taken_i      = ($urandom_range(0, 29) == 0);
      xret_i            = ($urandom_range(0, 29) == 0);
      pelp_restore_i    = $urandom_range(0, 1);
      xlpad_en_i        = ($urandom_range(0, 19) != 0);
      debug_mode_i      = ($urandom_range(0, 19) == 0);
      commit_valid_i    = ($urandom_range(0, 3) != 0);
      commit_is_ijump_i = $urandom_range(0, 1);
      commit_is_lpad_i  = !commit_is_ijump_i && ($urandom_range(0, 2) != 0);
      commit_rs1_i      = ($urandom_range(0, 2) == 0) ? 5'd5 : 5'($urandom);
      commit_x7_label_i = labs[$urandom_range(1, 3)];
      commit_lpad_label_i = ($urandom_range(0, 7) == 0) ? LW'($urandom) : labs[$urandom_range(0, 3)];
      step();
      n_cmp++; if (elp_o !== (m_exp || m_fault)) begin n_fail++; $display("FAIL rnd_elp @%0d: got %b want %b", i, elp_o, m_exp || m_fault); end
      n_cmp++; if (lp_fault_valid_o !== m_fault) begin n_fail++; $display("FAIL rnd_fault @%0d: got %b want %b", i, lp_fault_valid_o, m_fault); end
      n_cmp++; if (commit_ready_o !== !m_fault) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", i, commit_ready_o, !m_fault); end
      n_cmp++; if (pelp_o !== m_pelp) begin n_fail++; $display("FAIL rnd_pelp @%0d: got %b want %b", i, pelp_o, m_pelp); end
      n_cmp++; if (expected_label_o !== m_label) begin n_fail++; $display("FAIL rnd_label @%0d: got %h want %h", i, expected_label_o, m_label); end
    end
    quiet();
  endtask

  initial begin
    m_exp = 0; m_fault = 0; m_pelp = 0; m_label = '0;
    test_reset();
    test_match();
    test_mismatch_trap();
    test_zero_label_and_exempt();
    test_trap_xret();
    test_fault_reset();
    test_disabled();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
